cpu_ctrl: RTL and testbench

Multi-cycle main controller for the R/I/J-type MIPS CPU. It owns the instruction-execution state machine and, from the current instruction word, drives the `pc` block's next-PC select (`PC_s`) and PC write strobe. It also drives the instruction-register, register-file, data-memory and ALU controls. It is the single sequencer between the `pc` block, the register file, the ALU and the data RAM.

---
 rtl/cpu_ctrl_if.sv | 32 +++
 rtl/cpu_ctrl.sv | 138 +++++++++++++
 tb/tb_cpu_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_if.sv
// Control bundle between the main sequencer and the datapath.
// master is the controller side, slave is the datapath side.
interface cpu_ctrl_if;
  logic [31:0] Inst_code;
  logic        ZF;
  logic [1:0]  PC_s;
  logic        Write_PC;
  logic        Write_IR;
  logic        Write_Reg;
  logic        Mem_Write;
  logic [2:0]  ALU_OP;
  logic [1:0]  w_r_s;
  logic [1:0]  wr_data_s;
  logic        imm_s;
  logic        rt_imm_s;
  logic [2:0]  state;
  logic        illegal;

  modport master (
    input  Inst_code, ZF,
    output PC_s, Write_PC, Write_IR, Write_Reg, Mem_Write,
    output ALU_OP, w_r_s, wr_data_s, imm_s, rt_imm_s,
    output state, illegal
  );

  modport slave (
    output Inst_code, ZF,
    input  PC_s, Write_PC, Write_IR, Write_Reg, Mem_Write,
    input  ALU_OP, w_r_s, wr_data_s, imm_s, rt_imm_s,
    input  state, illegal
  );
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle MIPS main controller: IF/ID/EXE/MEM/WB sequencer
// driving PC, IR, register file, data RAM and ALU controls.
module cpu_ctrl (
  input  logic      clk,
  input  logic      rst,
  cpu_ctrl_if.master bus
);
  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXE = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  state_t cur, nxt;

  logic [5:0] op, fn;
  logic d_r, d_ialu, d_lw, d_sw, d_beq, d_bne;
  logic d_j, d_jal, d_jr, d_ok, d_sx;
  logic [2:0] d_alu;
  logic wir, wpc, wreg, memw, ill;
  logic [1:0] pcs, wrs, wds;
  logic unused_bits;

  assign op = bus.Inst_code[31:26];
  assign fn = bus.Inst_code[5:0];
  assign unused_bits = ^bus.Inst_code[25:6];

  always_comb begin
    d_r = 1'b0; d_ialu = 1'b0; d_lw = 1'b0;
    d_sw = 1'b0; d_beq = 1'b0; d_bne = 1'b0;
    d_j = 1'b0; d_jal = 1'b0; d_jr = 1'b0;
    d_sx = 1'b0; d_alu = 3'b000;
    unique case (op)
      6'b000000: begin
        unique case (fn)
          6'b100000: begin d_r = 1'b1; d_alu = 3'b100; end
          6'b100010: begin d_r = 1'b1; d_alu = 3'b101; end
          6'b100100: begin d_r = 1'b1; d_alu = 3'b000; end
          6'b100101: begin d_r = 1'b1; d_alu = 3'b001; end
          6'b100110: begin d_r = 1'b1; d_alu = 3'b010; end
          6'b100111: begin d_r = 1'b1; d_alu = 3'b011; end
          6'b101010: begin d_r = 1'b1; d_alu = 3'b110; end
          6'b000100: begin d_r = 1'b1; d_alu = 3'b111; end
          6'b001000: d_jr = 1'b1;
          default: ;
        endcase
      end
      6'b001000: begin d_ialu = 1'b1; d_alu = 3'b100; d_sx = 1'b1; end
      6'b001011: begin d_ialu = 1'b1; d_alu = 3'b110; d_sx = 1'b1; end
      6'b001100: begin d_ialu = 1'b1; d_alu = 3'b000; end
      6'b001101: begin d_ialu = 1'b1; d_alu = 3'b001; end
      6'b001110: begin d_ialu = 1'b1; d_alu = 3'b010; end
      6'b100011: begin d_lw = 1'b1; d_alu = 3'b100; d_sx = 1'b1; end
      6'b101011: begin d_sw = 1'b1; d_alu = 3'b100; d_sx = 1'b1; end
      6'b000100: begin d_beq = 1'b1; d_alu = 3'b101; d_sx = 1'b1; end
      6'b000101: begin d_bne = 1'b1; d_alu = 3'b101; d_sx = 1'b1; end
      6'b000010: d_j = 1'b1;
      6'b000011: d_jal = 1'b1;
      default: ;
    endcase
  end

  assign d_ok = d_r | d_ialu | d_lw | d_sw | d_beq | d_bne
              | d_j | d_jal | d_jr;

  always_ff @(posedge clk) begin
    if (rst) cur <= S_IF;
    else     cur <= nxt;
  end

  always_comb begin
    nxt  = S_IF;
    wir  = 1'b0;
    wpc  = 1'b0;
    wreg = 1'b0;
    memw = 1'b0;
    ill  = 1'b0;
    unique case (cur)
      S_IF: begin
        wir = 1'b1;
        wpc = 1'b1;
        nxt = S_ID;
      end
      S_ID: begin
        if (!d_ok) begin
          ill = 1'b1;
        end else if (d_j | d_jal | d_jr) begin
          wpc  = 1'b1;
          wreg = d_jal;
        end else begin
          nxt = S_EXE;
        end
      end
      S_EXE: begin
        if (d_beq | d_bne)
          wpc = (d_beq & bus.ZF) | (d_bne & ~bus.ZF);
        else if (d_lw | d_sw)
          nxt = S_MEM;
        else
          nxt = S_WB;
      end
      S_MEM: begin
        if (d_sw) memw = 1'b1;
        else      nxt  = S_WB;
      end
      S_WB: wreg = 1'b1;
      default: nxt = S_IF;
    endcase
  end

  // Fetch always selects PC+4; later states select from the decode.
  always_comb begin
    pcs = 2'b00;
    if (cur != S_IF) begin
      if (d_j | d_jal)        pcs = 2'b11;
      else if (d_jr)          pcs = 2'b01;
      else if (d_beq | d_bne) pcs = 2'b10;
    end
  end

  assign wrs = d_jal ? 2'b10 : (d_ialu | d_lw) ? 2'b01 : 2'b00;
  assign wds = d_jal ? 2'b10 : d_lw ? 2'b01 : 2'b00;

  assign bus.Write_IR  = wir  & ~rst;
  assign bus.Write_PC  = wpc  & ~rst;
  assign bus.Write_Reg = wreg & ~rst;
  assign bus.Mem_Write = memw & ~rst;
  assign bus.illegal   = ill  & ~rst;
  assign bus.PC_s      = rst ? 2'b00 : pcs;
  assign bus.w_r_s     = rst ? 2'b00 : wrs;
  assign bus.wr_data_s = rst ? 2'b00 : wds;
  assign bus.ALU_OP    = rst ? 3'b000 : d_alu;
  assign bus.imm_s     = ~rst & d_sx;
  assign bus.rt_imm_s  = ~rst & (d_ialu | d_lw | d_sw);
  assign bus.state     = cur;
endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: instruction-level model plus
// literal spot checks on directed instruction words.
module tb_cpu_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cpu_ctrl_if bus ();

  cpu_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef enum {C_ALU, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR, C_ILL} cls_t;

  typedef struct packed {
    logic [2:0] st;
    logic       wir, wpc, wreg, memw, ill;
    logic [1:0] pcs, wrs, wds;
    logic [2:0] alu;
    logic       imm, rti;
  } obs_t;

  obs_t exp_o;
  obs_t snap [5];
  bit   chk_en = 0;
  bit   pcs_chk, wr_chk, alu_chk;
  int   n_run = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_run++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Instruction-level meaning of each word.
  function automatic void decode(input logic [31:0] i, output cls_t c,
                                 output logic [2:0] alu,
                                 output logic imm, output logic rti,
                                 output bit is_bne, output bit is_r);
    logic [5:0] op, fn;
    op = i[31:26]; fn = i[5:0];
    c = C_ILL; alu = 3'b000; imm = 0; rti = 0; is_bne = 0; is_r = 0;
    case (op)
      6'h00: begin
        is_r = 1; c = C_ALU;
        case (fn)
          6'h20: alu = 3'b100;
          6'h22: alu = 3'b101;
          6'h24: alu = 3'b000;
          6'h25: alu = 3'b001;
          6'h26: alu = 3'b010;
          6'h27: alu = 3'b011;
          6'h2A: alu = 3'b110;
          6'h04: alu = 3'b111;
          6'h08: c = C_JR;
          default: c = C_ILL;
        endcase
      end
      6'h08: begin c = C_ALU; alu = 3'b100; imm = 1; rti = 1; end
      6'h0B: begin c = C_ALU; alu = 3'b110; imm = 1; rti = 1; end
      6'h0C: begin c = C_ALU; alu = 3'b000; rti = 1; end
      6'h0D: begin c = C_ALU; alu = 3'b001; rti = 1; end
      6'h0E: begin c = C_ALU; alu = 3'b010; rti = 1; end
      6'h23: begin c = C_LW;  alu = 3'b100; imm = 1; rti = 1; end
      6'h2B: begin c = C_SW;  alu = 3'b100; imm = 1; rti = 1; end
      6'h04: begin c = C_BR;  alu = 3'b101; imm = 1; end
      6'h05: begin c = C_BR;  alu = 3'b101; imm = 1; is_bne = 1; end
      6'h02: c = C_J;
      6'h03: c = C_JAL;
      default: c = C_ILL;
    endcase
  endfunction

  // Visited states per instruction class, in order.
  function automatic int path(input cls_t c, input int k);
    int p [5];
    int n;
    case (c)
      C_BR:    begin p = '{0, 1, 2, 0, 0}; n = 3; end
      C_SW:    begin p = '{0, 1, 2, 3, 0}; n = 4; end
      C_LW:    begin p = '{0, 1, 2, 3, 4}; n = 5; end
      C_ALU:   begin p = '{0, 1, 2, 4, 0}; n = 4; end
      default: begin p = '{0, 1, 0, 0, 0}; n = 2; end
    endcase
    return (k < 0) ? n : p[k];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", bus.state, exp_o.st);
      chk("Write_IR", bus.Write_IR, exp_o.wir);
      chk("Write_PC", bus.Write_PC, exp_o.wpc);
      chk("Write_Reg", bus.Write_Reg, exp_o.wreg);
      chk("Mem_Write", bus.Mem_Write, exp_o.memw);
      chk("illegal", bus.illegal, exp_o.ill);
      if (pcs_chk) chk("PC_s", bus.PC_s, exp_o.pcs);
      if (wr_chk) begin
        chk("w_r_s", bus.w_r_s, exp_o.wrs);
        chk("wr_data_s", bus.wr_data_s, exp_o.wds);
      end
      if (alu_chk) begin
        chk("ALU_OP", bus.ALU_OP, exp_o.alu);
        chk("imm_s", bus.imm_s, exp_o.imm);
        chk("rt_imm_s", bus.rt_imm_s, exp_o.rti);
      end
    end
  end

  task automatic step_snap(input int k);
    #3;
    snap[k] = '{bus.state, bus.Write_IR, bus.Write_PC, bus.Write_Reg,
                bus.Mem_Write, bus.illegal, bus.PC_s, bus.w_r_s,
                bus.wr_data_s, bus.ALU_OP, bus.imm_s, bus.rt_imm_s};
    @(posedge clk);
    #1;
  endtask

  // Runs cycles 0..maxk-1 of one instruction (maxk<=0 means all).
  task automatic run(input logic [31:0] i, input logic zf, input int maxk);
    cls_t c;
    logic [2:0] alu;
    logic imm, rti;
    bit bne, isr, last, taken;
    int n;
    decode(i, c, alu, imm, rti, bne, isr);
    n = path(c, -1);
    if (maxk > 0 && maxk < n) n = maxk;
    taken = (c == C_BR) && (bne ? !zf : zf);
    for (int k = 0; k < n; k++) begin
      last = (k == path(c, -1) - 1);
      bus.Inst_code = i;
      bus.ZF = zf;
      exp_o = '0;
      exp_o.st = path(c, k);
      exp_o.wir = (k == 0);
      exp_o.wpc = (k == 0) || (last && (c inside {C_J, C_JAL, C_JR}))
                  || (last && taken);
      exp_o.wreg = last && (c inside {C_JAL, C_ALU, C_LW});
      exp_o.memw = last && (c == C_SW);
      exp_o.ill = last && (c == C_ILL);
      exp_o.pcs = (k == 0) ? 2'b00 :
                  (c == C_J || c == C_JAL) ? 2'b11 :
                  (c == C_JR) ? 2'b01 : 2'b10;
      exp_o.wrs = (c == C_JAL) ? 2'b10 : isr ? 2'b00 : 2'b01;
      exp_o.wds = (c == C_JAL) ? 2'b10 : (c == C_LW) ? 2'b01 : 2'b00;
      exp_o.alu = alu;
      exp_o.imm = imm;
      exp_o.rti = rti;
      pcs_chk = exp_o.wpc;
      wr_chk = exp_o.wreg;
      alu_chk = (k > 0) && (c inside {C_ALU, C_LW, C_SW, C_BR});
      chk_en = 1;
      step_snap(k);
    end
  endtask

  task automatic reset_cycle(input logic [2:0] st);
    exp_o = '0;
    exp_o.st = st;
    pcs_chk = 1; wr_chk = 1; alu_chk = 1;
    chk_en = 1;
    step_snap(0);
  endtask

  logic [31:0] tbl_i [20] = '{
    32'h00221822, 32'h00221824, 32'h00221825, 32'h00221826,
    32'h00221827, 32'h0022182A, 32'h00221804, 32'h20220004,
    32'h2C22FFFC, 32'h34420F0F, 32'h38420F0F, 32'h14220003,
    32'h14220003, 32'h08000010, 32'h0022183F, 32'h8C220010,
    32'hAC220010, 32'h10220003, 32'h0C000020, 32'h00221820
  };
  logic tbl_z [20] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0,
                       0, 1, 0, 1, 0, 1, 0, 0, 1, 1};

  initial begin
    bus.Inst_code = 32'h0;
    bus.ZF = 1'b0;
    pcs_chk = 0; wr_chk = 0; alu_chk = 0;
    @(posedge clk);
    #1;
    reset_cycle(3'b000);
    rst = 1'b0;

    // add: IF ID EXE WB, single-cycle Write_Reg
    run(32'h00221820, 1'b0, 0);
    chk("add_wb_state", snap[3].st, 3'b100);
    chk("add_wb_aluop", snap[3].alu, 3'b100);
    chk("add_wb_wrs", snap[3].wrs, 2'b00);
    chk("add_wb_wreg", snap[3].wreg, 1);
    chk("add_exe_wreg", snap[2].wreg, 0);

    run(32'h8C220004, 1'b0, 0);
    chk("lw_wb_wds", snap[4].wds, 2'b01);
    chk("lw_wb_wrs", snap[4].wrs, 2'b01);
    chk("lw_exe_imm", snap[2].imm, 1);
    chk("lw_exe_rti", snap[2].rti, 1);

    run(32'hAC220004, 1'b0, 0);
    chk("sw_mem_memw", snap[3].memw, 1);
    chk("sw_exe_memw", snap[2].memw, 0);

    run(32'h10220003, 1'b1, 0);
    chk("beq_t_wpc", snap[2].wpc, 1);
    chk("beq_t_pcs", snap[2].pcs, 2'b10);
    run(32'h10220003, 1'b0, 0);
    chk("beq_nt_wpc", snap[2].wpc, 0);
    run(32'h14220003, 1'b0, 0);
    chk("bne_t_wpc", snap[2].wpc, 1);
    run(32'h14220003, 1'b1, 0);
    chk("bne_nt_wpc", snap[2].wpc, 0);

    run(32'h0C000010, 1'b0, 0);
    chk("jal_id_pcs", snap[1].pcs, 2'b11);
    chk("jal_id_wpc", snap[1].wpc, 1);
    chk("jal_id_wreg", snap[1].wreg, 1);
    chk("jal_id_wrs", snap[1].wrs, 2'b10);
    chk("jal_id_wds", snap[1].wds, 2'b10);

    run(32'h03E00008, 1'b0, 0);
    chk("jr_id_pcs", snap[1].pcs, 2'b01);

    run(32'hFC000000, 1'b0, 0);
    chk("ill_id_pulse", snap[1].ill, 1);
    chk("ill_id_wpc", snap[1].wpc, 0);

    run(32'h30420F0F, 1'b0, 0);
    chk("andi_imm", snap[2].imm, 0);
    chk("andi_alu", snap[2].alu, 3'b000);

    for (int t = 0; t < 20; t++) run(tbl_i[t], tbl_z[t], 0);

    // Reset held two cycles starting in WB of an add.
    run(32'h00221820, 1'b0, 3);
    rst = 1'b1;
    reset_cycle(3'b100);
    chk("rst_wb_wreg", snap[0].wreg, 0);
    reset_cycle(3'b000);
    rst = 1'b0;
    run(32'h00221820, 1'b0, 0);
    chk("post_rst_wir", snap[0].wir, 1);
    chk("post_rst_pcs", snap[0].pcs, 2'b00);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
